// File: rtl/ysyx_22041752_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, RV32 opcodes and the queue entry width.
package ysyx_22041752_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_REQ       = 3'd1,
    S_RESP      = 3'd2,
    S_DROP_REQ  = 3'd3,
    S_DROP_RESP = 3'd4
  } fetch_state_e;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Queue entry layout: {pc, inst, pred_taken, pred_target}.
  function automatic int fq_entry_width(input int pc_wd, input int inst_wd);
    return 2 * pc_wd + inst_wd + 1;
  endfunction

endpackage

// File: rtl/ysyx_22041752_fetch_unit_fetch_queue.sv
// Circular FIFO with wrapping head/tail pointers; clear has priority over push and pop.
module ysyx_22041752_fetch_queue
  #(parameter int WIDTH = 97,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1)
  (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22041752_fetch_unit.sv
// Instruction fetch stage: one-outstanding request FSM with flush drop states and a fetch queue.
// Define YSYX_22041752_STATIC_BP_EN to enable static next-PC prediction (jal, backward branch, jalr).
module ysyx_22041752_fetch_unit
  import ysyx_22041752_fetch_unit_pkg::*;
  #(parameter int               PC_WD    = 32,
    parameter int               INST_WD  = 32,
    parameter logic [PC_WD-1:0] RESET_PC = PC_WD'(32'h8000_0000),
    parameter int               FQ_DEPTH = 2)
  (
  input  logic               clk,
  input  logic               reset,
  output logic               inst_req,
  output logic [PC_WD-1:0]   inst_addr,
  input  logic               inst_ready,
  input  logic               inst_rvalid,
  input  logic [INST_WD-1:0] inst_rdata,
  input  logic [PC_WD-1:0]   ra_data,
  input  logic               flush,
  input  logic [PC_WD-1:0]   flush_pc,
  input  logic               ds_allowin,
  output logic               fs_to_ds_valid,
  output logic [PC_WD-1:0]   ds_pc,
  output logic [INST_WD-1:0] ds_inst,
  output logic               ds_pred_taken,
  output logic [PC_WD-1:0]   ds_pred_target,
  output logic [2:0]         dbg_state
);

  localparam int                 ENTRY_W  = fq_entry_width(PC_WD, INST_WD);
  localparam int                 CNT_W    = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FQ_DEPTH);

  // Handshake: the memory accepts a request on a cycle with inst_req && inst_ready;
  // inst_addr holds while inst_req && !inst_ready; exactly one inst_rvalid answers
  // each accepted request. Decode takes the head on fs_to_ds_valid && ds_allowin.

  fetch_state_e       state_q, state_d;
  logic [PC_WD-1:0]   fetch_pc;
  logic [PC_WD-1:0]   drop_addr;
  logic [CNT_W-1:0]   q_count;
  logic [CNT_W-1:0]   cnt_after;
  logic               push, pop;
  logic               pred_taken;
  logic [PC_WD-1:0]   pred_target;
  logic [PC_WD-1:0]   pc_plus4;
  logic [ENTRY_W-1:0] push_data, head_data;

  assign dbg_state      = state_q;
  assign fs_to_ds_valid = (q_count != '0) && !flush;
  assign pop            = fs_to_ds_valid && ds_allowin;
  assign push           = (state_q == S_RESP) && inst_rvalid && !flush;
  assign cnt_after      = q_count + CNT_W'(1) - CNT_W'(pop);
  assign pc_plus4       = fetch_pc + PC_WD'(4);

`ifdef YSYX_22041752_STATIC_BP_EN
  logic [6:0]       opcode;
  logic [PC_WD-1:0] imm_j, imm_b, imm_i;

  assign opcode = inst_rdata[6:0];
  assign imm_j  = {{(PC_WD-20){inst_rdata[31]}}, inst_rdata[19:12], inst_rdata[20],
                   inst_rdata[30:21], 1'b0};
  assign imm_b  = {{(PC_WD-12){inst_rdata[31]}}, inst_rdata[7], inst_rdata[30:25],
                   inst_rdata[11:8], 1'b0};
  assign imm_i  = {{(PC_WD-12){inst_rdata[31]}}, inst_rdata[31:20]};

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    unique case (opcode)
      OP_JAL: begin
        pred_taken  = 1'b1;
        pred_target = fetch_pc + imm_j;
      end
      OP_BRANCH: begin
        // Backward branches are predicted taken (loop heuristic).
        if (inst_rdata[31]) begin
          pred_taken  = 1'b1;
          pred_target = fetch_pc + imm_b;
        end
      end
      OP_JALR: begin
        pred_taken  = 1'b1;
        pred_target = (ra_data + imm_i) & ~PC_WD'(1);
      end
      default: ;
    endcase
  end
`else
  logic unused_ra;

  assign unused_ra   = ^ra_data;
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  assign push_data = {fetch_pc, inst_rdata, pred_taken, pred_target};
  assign ds_pc          = head_data[ENTRY_W-1 -: PC_WD];
  assign ds_inst        = head_data[PC_WD+1 +: INST_WD];
  assign ds_pred_taken  = head_data[PC_WD];
  assign ds_pred_target = head_data[PC_WD-1:0];

  ysyx_22041752_fetch_queue #(.WIDTH(ENTRY_W), .DEPTH(FQ_DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    inst_req  = 1'b0;
    inst_addr = fetch_pc;
    unique case (state_q)
      S_WAIT: begin
        if (flush || q_count < FULL_CNT) state_d = S_REQ;
      end
      S_REQ: begin
        inst_req = 1'b1;
        if (inst_ready) state_d = flush ? S_DROP_RESP : S_RESP;
        else if (flush) state_d = S_DROP_REQ;
      end
      S_RESP: begin
        if (inst_rvalid) begin
          if (flush)                     state_d = S_REQ;
          else if (cnt_after < FULL_CNT) state_d = S_REQ;
          else                           state_d = S_WAIT;
        end else if (flush) begin
          state_d = S_DROP_RESP;
        end
      end
      S_DROP_REQ: begin
        // The abandoned request must stay on the bus unchanged until accepted.
        inst_req  = 1'b1;
        inst_addr = drop_addr;
        if (inst_ready) state_d = S_DROP_RESP;
      end
      S_DROP_RESP: begin
        if (inst_rvalid) state_d = S_REQ;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      if (flush)     fetch_pc <= flush_pc;
      else if (push) fetch_pc <= pred_target;
      if (state_q == S_REQ && flush && !inst_ready) drop_addr <= fetch_pc;
    end
  end

endmodule
